// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: program RAM loaded over valid/ready, 1-cycle registered fetch port.
// Optional macro FETCH_PARITY_EN stores an even-parity bit per word and checks it on fetch.
module instr_mem_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9,
    parameter logic [DATA_W-1:0] NOP_WORD = 9'b111_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_direccion_instruccion,
    output logic [DATA_W-1:0] o_instruccion,
    output logic              o_valida,
    input  logic              i_prog_en,
    input  logic              i_prog_valid,
    input  logic [DATA_W-1:0] i_prog_data,
    output logic              o_prog_ready,
    output logic [ADDR_W:0]   o_prog_count,
    output logic              o_prog_done,
    output logic              o_error
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

`ifdef FETCH_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic [DATA_W-1:0] rd_data;
    logic              fetch;
    logic              in_range;
    logic              par_bad;
    logic              wr_en;
    logic              overflow;

    assign o_prog_count = count;
    assign o_prog_ready = (state == LOAD) && (count < FULL);

    // Falling i_prog_en takes priority over a loader word on the same edge.
    assign wr_en    = (state == LOAD) && i_prog_en && i_prog_valid && o_prog_ready;
    assign overflow = (state == LOAD) && i_prog_en && i_prog_valid && !o_prog_ready;

    // The LOAD->RUN edge already fetches, so RUN's first cycle shows a word.
    assign fetch    = !i_prog_en && ((state == LOAD) || (state == RUN));
    assign in_range = {1'b0, i_direccion_instruccion} < count;
    assign rd_word  = mem[i_direccion_instruccion];
    assign rd_data  = rd_word[DATA_W-1:0];

`ifdef FETCH_PARITY_EN
    assign wr_word = {^i_prog_data, i_prog_data};
    assign par_bad = ^rd_word;
`else
    assign wr_word = i_prog_data;
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[ADDR_W-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count         <= '0;
            o_instruccion <= NOP_WORD;
            o_valida      <= 1'b0;
            o_prog_done   <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_prog_done   <= 1'b0;
            o_instruccion <= NOP_WORD;
            o_valida      <= 1'b0;
            if (overflow || (fetch && in_range && par_bad)) begin
                o_error <= 1'b1;
            end
            if (fetch && in_range && !par_bad) begin
                o_instruccion <= rd_data;
                o_valida      <= 1'b1;
            end
            if (wr_en) begin
                count <= count + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_prog_en) begin
                        state <= LOAD;
                        count <= '0;
                    end
                end
                LOAD: begin
                    if (!i_prog_en) begin
                        state       <= RUN;
                        o_prog_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_prog_en) begin
                        state <= LOAD;
                        count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
